// File: rtl/i2s_receiver_pkg.sv
// Shared constants and types for the I2S capture path: timebase layout,
// word size and the sample-strobe phase helper.
package i2s_receiver_pkg;

    localparam int I2S_CNT_WIDTH = 10;
    localparam int I2S_SLOTS     = 32;
    localparam int I2S_WORD      = 16;

    localparam int MCLK_BIT = 1;
    localparam int SCK_BIT  = 4;
    localparam int LRCK_BIT = 9;

    localparam int SLOT_WIDTH = $clog2(I2S_SLOTS);

    typedef logic [I2S_WORD-1:0]   sample_t;
    typedef logic [SLOT_WIDTH-1:0] slot_t;
    typedef logic [SCK_BIT:0]      phase_t;

    // Slot 16 closes the left word; slot 0 of the next frame closes the right word.
    localparam slot_t SLOT_LEFT_DONE  = slot_t'(16);
    localparam slot_t SLOT_RIGHT_DONE = slot_t'(0);

    // sck rises at phase 16; the synchronizer pushes the usable sample later.
    function automatic phase_t strobe_phase(input int stages);
        return phase_t'(16 + stages);
    endfunction

endpackage

// File: rtl/i2s_receiver_if.sv
// Stereo sample handshake between the I2S receiver and the sound logic.
interface i2s_receiver_if;
    import i2s_receiver_pkg::*;

    sample_t sample_left;
    sample_t sample_right;
    logic    sample_valid;
    logic    sample_ready;
    logic    overrun;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        output overrun,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        input  overrun,
        output sample_ready
    );

endinterface

// File: rtl/i2s_sync_shift.sv
// ADC data synchronizer followed by the serial-to-parallel shift register,
// advanced once per bit slot by the sample strobe.
module i2s_sync_shift
    import i2s_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    sdout,
    input  logic    strobe,
    output sample_t word,
    output sample_t word_next
);

    logic [SYNC_STAGES-1:0] sync;

    assign word_next = {word[I2S_WORD-2:0], sync[SYNC_STAGES-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            word <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sdout};
            if (strobe) begin
                word <= word_next;
            end
        end
    end

endmodule

// File: rtl/i2s_receiver.sv
// I2S master receiver: derives mclk/sck/lrck from one free-running counter,
// deserializes the ADC stream and hands stereo pairs out on valid/ready.
module i2s_receiver
    import i2s_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    output logic           audio_mclk,
    output logic           audio_sck,
    output logic           audio_lrck,
    input  logic           audio_sdout,
    i2s_receiver_if.master bus
);

    logic [I2S_CNT_WIDTH-1:0] cnt;
    slot_t                    slot;
    logic                     strobe;
    sample_t                  word;
    sample_t                  word_next;
    sample_t                  left_hold;
    logic                     primed;
    logic                     pair_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign audio_mclk = cnt[MCLK_BIT];
    assign audio_sck  = cnt[SCK_BIT];
    assign audio_lrck = cnt[LRCK_BIT];

    assign slot   = cnt[I2S_CNT_WIDTH-1 -: SLOT_WIDTH];
    assign strobe = (cnt[SCK_BIT:0] == strobe_phase(SYNC_STAGES));

    i2s_sync_shift #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_shift (
        .clk       (clk),
        .rst       (rst),
        .sdout     (audio_sdout),
        .strobe    (strobe),
        .word      (word),
        .word_next (word_next)
    );

    // primed stays low until a full left word has been seen, so the first
    // slot-0 close after reset never produces a half-empty pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_hold <= '0;
            primed    <= 1'b0;
            pair_pend <= 1'b0;
        end else begin
            pair_pend <= 1'b0;
            if (strobe && slot == SLOT_LEFT_DONE) begin
                left_hold <= word_next;
                primed    <= 1'b1;
            end
            if (strobe && slot == SLOT_RIGHT_DONE) begin
                pair_pend <= primed;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sample_left  <= '0;
            bus.sample_right <= '0;
            bus.sample_valid <= 1'b0;
            bus.overrun      <= 1'b0;
        end else if (pair_pend) begin
            bus.sample_left  <= left_hold;
            bus.sample_right <= word;
            bus.sample_valid <= 1'b1;
            bus.overrun      <= bus.overrun | (bus.sample_valid & ~bus.sample_ready);
        end else if (bus.sample_valid && bus.sample_ready) begin
            bus.sample_valid <= 1'b0;
        end
    end

endmodule
